// File: rtl/mult8_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult8_pkg
// Purpose  : Shared types and constants for the sequential 8x8 shift-and-add
//            multiplier and its ripple-carry adder stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult8_pkg;

  // Operand width; the product is twice as wide.
  localparam int WIDTH     = 8;
  localparam int PROD_W    = 2 * WIDTH;

  // The iteration carrying this count value is the last one before DONE.
  localparam int ITER_LAST = WIDTH - 1;

  // Iteration counter width.
  localparam int CNT_W     = $clog2(WIDTH);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult8_pkg

`default_nettype wire

// File: rtl/add8_cout.sv
//------------------------------------------------------------------------------
// Module   : add8_cout
// Purpose  : Ripple-carry adder built from one half adder (bit 0) and full
//            adders (upper bits). Returns {carry_out, sum} as ADD_W+1 bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module add8_cout
  import mult8_pkg::*;
#(
  parameter int ADD_W = WIDTH
) (
  input  logic [ADD_W-1:0] x,
  input  logic [ADD_W-1:0] y,
  output logic [ADD_W:0]   sum
);

  // w_c[i] is the carry into bit i; w_c[ADD_W] is the carry out.
  logic [ADD_W:1]   w_c;
  logic [ADD_W-1:0] w_s;

  for (genvar i = 0; i < ADD_W; i++) begin : g_bit
    if (i == 0) begin : g_ha
      // No carry into the LSB, so a half adder suffices.
      assign w_s[i]   = x[i] ^ y[i];
      assign w_c[i+1] = x[i] & y[i];
    end else begin : g_fa
      assign w_s[i]   = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign sum = {w_c[ADD_W], w_s};

endmodule : add8_cout

`default_nettype wire

// File: rtl/mult8_shift_add.sv
//------------------------------------------------------------------------------
// Module   : mult8_shift_add
// Purpose  : Sequential unsigned 8x8 shift-and-add multiplier. One iteration
//            per clock through an 8-bit ripple adder; 16-bit product and a
//            one-cycle done pulse.
// Options  : MULT8_ZERO_SKIP_EN - a zero operand finishes after a single
//            cycle instead of running all eight iterations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult8_shift_add
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LAST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_m;
  logic [PROD_W-1:0]   r_p;
  logic [WIDTH:0]      w_sum;

  // Upper half of the partial product plus the multiplicand, with carry out.
  add8_cout #(
    .ADD_W (WIDTH)
  ) u_add (
    .x   (r_p[PROD_W-1:WIDTH]),
    .y   (r_m),
    .sum (w_sum)
  );

  // Controller, iteration counter, operand and partial-product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_p     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
`ifdef MULT8_ZERO_SKIP_EN
            // A zero operand gives a zero product: clear P and preload the
            // counter so the single RUN cycle is the last iteration, which
            // lands done exactly one cycle after the start edge.
            if ((a == '0) || (b == '0)) begin
              r_p   <= '0;
              r_cnt <= CNT_LAST;
            end else begin
              r_p   <= {{WIDTH{1'b0}}, b};
            end
`else
            r_p     <= {{WIDTH{1'b0}}, b};
`endif
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end

        RUN: begin
          // Add the multiplicand when the current multiplier bit is set, then
          // shift the whole partial product right by one (carry enters MSB).
          if (r_p[0]) begin
            r_p <= {w_sum, r_p[WIDTH-1:1]};
          end else begin
            r_p <= {1'b0, r_p[PROD_W-1:1]};
          end
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The partial-product register is the result; it holds until the next start.
  assign product = r_p;

endmodule : mult8_shift_add

`default_nettype wire

// File: tb/tb_mult8_shift_add.sv
//------------------------------------------------------------------------------
// Module   : tb_mult8_shift_add
// Purpose  : Self-checking bench for mult8_shift_add. Expected products come
//            from plain multiplication; expected latencies from the timing
//            rules (8 edges, or 1 edge for a zero operand with skip enabled).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult8_shift_add;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total;
  int bad;

  mult8_shift_add dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_latency(input logic [7:0] ta, input logic [7:0] tb_v);
`ifdef MULT8_ZERO_SKIP_EN
    if (ta == 8'd0 || tb_v == 8'd0) return 1;
`endif
    return 8;
  endfunction

  // One full transaction; optionally re-pulses start (with other operands)
  // repulse cycles after acceptance, which must be ignored.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb_v, input int repulse);
    int k;
    int busy_cnt;
    int exp_lat;
    logic [15:0] exp_p;
    exp_lat = model_latency(ta, tb_v);
    exp_p   = 16'(ta * tb_v);
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; busy_cnt = 0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      if (k == repulse) begin
        start = 1'b1; a = 8'd7; b = 8'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    check("latency", k, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("product", {16'd0, product}, {16'd0, exp_p});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("product_hold", {16'd0, product}, {16'd0, exp_p});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    int k;
    int seen;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_mult(8'd13, 8'd11, -1);
    do_mult(8'hFF, 8'hFF, -1);
    do_mult(8'd3, 8'd5, 2);
    do_mult(8'd0, 8'hAB, -1);
    do_mult(8'hAB, 8'd0, -1);

    // Reset in the middle of a run
    a = 8'd200; b = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("midrst_quiet", seen, 0);
    do_mult(8'd2, 8'd9, -1);

    // start and rst together: reset wins
    rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd5;
    tick();
    check("rst_wins_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; rst = 1'b0;
    tick();

    // Back-to-back with start held high
    for (int n = 0; n < 4; n++) begin
      ba[n] = 8'($urandom_range(1, 255));
      bb[n] = 8'($urandom_range(1, 255));
    end
    a = ba[0]; b = bb[0]; start = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      k = 0;
      while (!done && k < 20) begin
        tick();
        k++;
      end
      check("b2b_latency", k, 8);
      check("b2b_product", {16'd0, product}, {16'd0, 16'(ba[n] * bb[n])});
      if (n < 3) begin
        a = ba[n+1]; b = bb[n+1];
      end else begin
        start = 1'b0;
      end
      tick();
      check("b2b_done_low", {31'd0, done}, 32'd0);
      check("b2b_busy", {31'd0, busy}, (n < 3) ? 32'd1 : 32'd0);
    end
    tick();

    // Randomized operands, some zero, some with ignored re-pulses
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int rp;
      ra = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      rp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
      do_mult(ra, rb, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mult8_shift_add

`default_nettype wire
